// File: rtl/mips_seq_divider_pkg.sv
// Shared definitions for the sequential MIPS divider: FSM encoding,
// default operand width and the CLA group-propagate/generate helper.
package mips_seq_divider_pkg;

  localparam int DIV_WIDTH_DEF = 32;
  localparam int CLA_CELL_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Group {G, P} of one 4-bit lookahead cell from its bit-level g/p.
  function automatic logic [1:0] cla4_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    logic pg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg = &p;
    return {gg, pg};
  endfunction

endpackage

// File: rtl/mips_seq_divider_cla_sub_nbit.sv
// N-bit subtractor A - B = A + ~B + 1 built from 4-bit CLA cells with
// group P/G lookahead between cells; bits beyond the last full cell
// ripple as 1-bit stages. NoBorrow is the final carry-out.

// One 4-bit lookahead cell. Group G/P depend only on the operands, so the
// group-carry network never loops back through the cell's carry-in.
module cla4_cell
  import mips_seq_divider_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b_n,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       grp_g,
  output logic       grp_p
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b_n;
  assign g = a & b_n;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign sum = p ^ c;
  assign {grp_g, grp_p} = cla4_gp(g, p);
endmodule

module cla_sub_nbit
  import mips_seq_divider_pkg::*;
#(
  parameter int N = DIV_WIDTH_DEF + 1
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Diff,
  output logic         NoBorrow
);
  localparam int NC = N / CLA_CELL_W;
  localparam int NR = N - NC * CLA_CELL_W;

  logic [N-1:0]            b_n;
  logic [NC-1:0]           grp_g;
  logic [NC-1:0]           grp_p;
  logic [NC:0]             grp_c;
  logic [CLA_CELL_W*NC-1:0] cell_sum;

  assign b_n = ~B;

  // Group carry chain: carry-in of 1 supplies the +1 of two's complement.
  always_comb begin
    logic c;
    c        = 1'b1;
    grp_c[0] = c;
    for (int i = 0; i < NC; i++) begin
      c          = grp_g[i] | (grp_p[i] & c);
      grp_c[i+1] = c;
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_cell
    cla4_cell u_cell (
      .a     (A[CLA_CELL_W*i +: CLA_CELL_W]),
      .b_n   (b_n[CLA_CELL_W*i +: CLA_CELL_W]),
      .ci    (grp_c[i]),
      .sum   (cell_sum[CLA_CELL_W*i +: CLA_CELL_W]),
      .grp_g (grp_g[i]),
      .grp_p (grp_p[i])
    );
  end

  if (NR > 0) begin : g_tail
    logic [NR-1:0] tail_sum;
    logic          tail_c;

    // Leftover top bits ripple off the last group carry.
    always_comb begin
      logic c;
      c = grp_c[NC];
      for (int j = 0; j < NR; j++) begin
        tail_sum[j] = A[CLA_CELL_W*NC+j] ^ b_n[CLA_CELL_W*NC+j] ^ c;
        c = (A[CLA_CELL_W*NC+j] & b_n[CLA_CELL_W*NC+j]) |
            ((A[CLA_CELL_W*NC+j] ^ b_n[CLA_CELL_W*NC+j]) & c);
      end
      tail_c = c;
    end

    assign Diff     = {tail_sum, cell_sum};
    assign NoBorrow = tail_c;
  end else begin : g_no_tail
    assign Diff     = cell_sum;
    assign NoBorrow = grp_c[NC];
  end
endmodule

// File: rtl/mips_seq_divider.sv
// Restoring sequential divider for DIV/DIVU. One quotient bit per clock,
// operands reduced to magnitudes at capture, sign correction and the
// divide-by-zero override applied in a single FIX cycle.
module mips_seq_divider
  import mips_seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // The settled partial remainder is always below |Divisor|, so it fits
  // WIDTH bits; the extra bit exists only in the shifted trial value.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             out_dz_q, out_dz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic             trial_msb_unused;

  // Shifted partial remainder pulls in the next dividend bit from Q's MSB.
  assign r_sh = {rem_q, quo_q[WIDTH-1]};

  cla_sub_nbit #(.N(WIDTH + 1)) u_sub (
    .A        (r_sh),
    .B        ({1'b0, dmag_q}),
    .Diff     (trial),
    .NoBorrow (no_borrow)
  );

  // Whenever the trial is kept there was no borrow, so its MSB is zero.
  assign trial_msb_unused = trial[WIDTH];

  // Next-state, datapath and result-register update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dmag_d    = dmag_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    out_quo_d = out_quo_q;
    out_rem_d = out_rem_q;
    out_dz_d  = out_dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_CALC;
          cnt_d   = CW'(WIDTH - 1);
          rem_d   = '0;
          // Magnitudes: the most negative value negates onto itself,
          // which reads correctly as 2^(WIDTH-1) unsigned.
          quo_d   = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
          dmag_d  = (Signed && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
          negq_d  = Signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
          negr_d  = Signed & Dividend[WIDTH-1];
          dz_d    = (Divisor == '0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], no_borrow};
        rem_d = no_borrow ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        // With a zero divisor every trial succeeds, leaving Q all ones and
        // R = |Dividend|; the sign fix then restores the captured dividend.
        out_quo_d = dz_q ? '1 : (negq_q ? -quo_q : quo_q);
        out_rem_d = negr_q ? -rem_q : rem_q;
        out_dz_d  = dz_q;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dmag_q    <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dz_q      <= 1'b0;
      out_quo_q <= '0;
      out_rem_q <= '0;
      out_dz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dmag_q    <= dmag_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dz_q      <= dz_d;
      out_quo_q <= out_quo_d;
      out_rem_q <= out_rem_d;
      out_dz_q  <= out_dz_d;
    end
  end

  assign Busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign Done      = (state_q == S_DONE);
  assign Quotient  = out_quo_q;
  assign Remainder = out_rem_q;
  assign DivZero   = out_dz_q;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed bench for mips_seq_divider: vector table plus handshake,
// back-to-back and asynchronous-reset sequences. Latency is counted in
// rising edges, including the edge that samples Start.
module tb_mips_seq_divider;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Start;
  logic        Signed;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivZero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  localparam int NVEC   = 14;
  localparam int LAT    = 34;
  localparam int BUSYC  = 33;

  vec_t vecs [NVEC];

  mips_seq_divider #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Start     (Start),
    .Signed    (Signed),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivZero   (DivZero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after the edge that sampled Start (lat0 edges so far).
  // Drops Start at the next falling edge, then waits for Done.
  task automatic wait_done(input int lat0, output int lat, output int busy_cyc, output bit ok);
    lat      = lat0;
    busy_cyc = 0;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Done) begin
        ok = 1'b1;
        break;
      end
      if (Busy) busy_cyc++;
      @(posedge CLK);
      lat++;
    end
  endtask

  task automatic chk_result(input string tag, input vec_t v, input bit ok);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_q"},  Quotient,       v.q);
    chk({tag, "_r"},  Remainder,      v.r);
    chk({tag, "_dz"}, 32'(DivZero),   32'(v.dz));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int bc;
    bit ok;
    @(negedge CLK);
    Signed   = v.sgn;
    Dividend = v.a;
    Divisor  = v.b;
    Start    = 1'b1;
    @(posedge CLK);
    wait_done(1, lat, bc, ok);
    chk_result(tag, v, ok);
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(BUSYC));
    @(negedge CLK);
    chk({tag, "_done_pulse"}, {30'd0, Done, Busy}, 32'd0);
  endtask

  initial begin
    int   lat;
    int   bc;
    bit   ok;
    int   seen;
    vec_t v;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[3]  = '{1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  1'b1};
    vecs[4]  = '{1'b1, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  1'b1};
    vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[7]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1};
    vecs[10] = '{1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
    vecs[12] = '{1'b1, 32'h80000000,  32'd2,         32'hC0000000,  32'd0,         1'b0};
    vecs[13] = '{1'b0, 32'hDEADBEEF,  32'h00001000,  32'h000DEADB,  32'h00000EEF,  1'b0};

    RSTn     = 1'b0;
    Start    = 1'b0;
    Signed   = 1'b0;
    Dividend = '0;
    Divisor  = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy),    32'd0);
    chk("rst_done", 32'(Done),    32'd0);
    chk("rst_q",    Quotient,     32'd0);
    chk("rst_r",    Remainder,    32'd0);
    chk("rst_dz",   32'(DivZero), 32'd0);
    RSTn = 1'b1;

    // Vector table
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed mid-CALC with different operands must be ignored
    @(negedge CLK);
    Signed = 1'b0; Dividend = 32'd100; Divisor = 32'd7; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    Signed = 1'b1; Dividend = 32'h00001000; Divisor = 32'd3; Start = 1'b1;
    @(posedge CLK);
    wait_done(6, lat, bc, ok);
    chk_result("midstart", vecs[0], ok);
    chk("midstart_latency", 32'(lat), 32'(LAT));

    // Asynchronous reset at CALC iteration 10; outputs above hold 14/2
    @(negedge CLK);
    Signed = 1'b0; Dividend = 32'hDEADBEEF; Divisor = 32'h1000; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("arst_busy", 32'(Busy),    32'd0);
    chk("arst_done", 32'(Done),    32'd0);
    chk("arst_q",    Quotient,     32'd0);
    chk("arst_r",    Remainder,    32'd0);
    chk("arst_dz",   32'(DivZero), 32'd0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done || Busy) seen++;
    end
    chk("arst_no_done", 32'(seen), 32'd0);
    run_vec(vecs[0], "post_rst");

    // Back-to-back: Start held in the DONE cycle
    @(negedge CLK);
    Signed = 1'b1; Dividend = 32'hFFFFFFF9; Divisor = 32'd2; Start = 1'b1;
    @(posedge CLK);
    wait_done(1, lat, bc, ok);
    chk_result("b2b_first", vecs[1], ok);
    chk("b2b_first_latency", 32'(lat), 32'(LAT));
    Signed = 1'b1; Dividend = 32'd7; Divisor = 32'hFFFFFFFE; Start = 1'b1;
    @(posedge CLK);
    #1;
    chk("b2b_busy_rise", 32'(Busy), 32'd1);
    wait_done(1, lat, bc, ok);
    v = vecs[2];
    chk_result("b2b_second", v, ok);
    chk("b2b_second_latency", 32'(lat), 32'(LAT));
    chk("b2b_second_busy", 32'(bc), 32'(BUSYC));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
